d_ff: RTL and testbench



---
 rtl/d_ff_pkg.sv | 8 +
 rtl/d_ff.sv | 24 ++
 tb/tb_d_ff.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/d_ff_pkg.sv
// rtl/d_ff_pkg.sv - shared constants for the d_ff storage element
package d_ff_pkg;

    // Bit value replicated across the register width when no explicit
    // reset value is given by the parent.
    localparam bit D_FF_RESET_VALUE = 1'b0;

endpackage : d_ff_pkg

// File: rtl/d_ff.sv
// rtl/d_ff.sv - parameterizable rising-edge D register with synchronous active-low reset
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{D_FF_RESET_VALUE}}
) (
    input  logic [WIDTH-1:0] D,
    input  logic             clk,
    input  logic             async_reset,
    output logic [WIDTH-1:0] Q
);

    // Capture D every rising edge; a low async_reset (sampled, not asynchronous)
    // takes priority and loads RESET_VALUE instead.
    always_ff @(posedge clk) begin
        if (!async_reset) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= D;
        end
    end

endmodule : d_ff

// File: tb/tb_d_ff.sv
// tb/tb_d_ff.sv - scoreboard bench for d_ff (1-bit default and 8-bit 8'hA5 instances)
module tb_d_ff;

    typedef struct {
        logic       q1;
        logic [7:0] q8;
        string      name;
    } exp_t;

    logic       clk;
    logic       async_reset;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    exp_t exp_q[$];
    int   errors;
    int   checks;
    bit   stim_done;

    d_ff u_dut1 (
        .D           (d1),
        .clk         (clk),
        .async_reset (async_reset),
        .Q           (q1)
    );

    d_ff #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .D           (d8),
        .clk         (clk),
        .async_reset (async_reset),
        .Q           (q8)
    );

    // 20 ns clock, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s q1: got %b, required %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s q8: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Apply inputs in the low phase, queue the hand-computed result for the
    // coming rising edge, then wait until that edge has passed.
    task automatic step(input logic r, input logic dv1, input logic [7:0] dv8,
                        input bit glitch, input logic e1, input logic [7:0] e8,
                        input string name);
        exp_t e;
        async_reset = r;
        d1          = dv1;
        d8          = dv8;
        e.q1        = e1;
        e.q8        = e8;
        e.name      = name;
        exp_q.push_back(e);
        if (glitch) begin
            #2;
            d1 = ~dv1;
            d8 = ~dv8;
            #2;
            d1 = dv1;
            d8 = dv8;
        end
        @(negedge clk);
    endtask

    // Monitor: just after each rising edge pop and compare, then re-check just
    // before the next edge to prove Q ignored the low-phase input activity.
    initial begin
        exp_t cur;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (!stim_done) begin
                    checks++;
                    errors++;
                    $display("FAIL underflow: no expectation queued at %0t, required one", $time);
                end
            end else begin
                cur = exp_q.pop_front();
                check1(cur.name, q1, cur.q1);
                check8(cur.name, q8, cur.q8);
                #17;
                check1({cur.name, "_hold"}, q1, cur.q1);
                check8({cur.name, "_hold"}, q8, cur.q8);
            end
        end
    end

    initial begin
        errors      = 0;
        checks      = 0;
        stim_done   = 1'b0;
        async_reset = 1'b0;
        d1          = 1'b1;
        d8          = 8'h3C;

        //   rst   d1    d8     glitch q1    q8
        step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, "rst_a");
        step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, "rst_b");
        step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, "rst_c");
        step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, "release");
        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, "tog_0a");
        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, "tog_0b");
        step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, "tog_1a");
        step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, "tog_1b");
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "glitch");
        step(1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 8'h81, "set_one");
        step(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 8'hA5, "mid_rst");
        step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b0, 8'hA5, "rst_wins");
        step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, "deassert");
        step(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01, "last");

        stim_done = 1'b1;
        #10;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_d_ff
